io_bus_arbiter: RTL and testbench
=================================

Name: io_bus_arbiter

Overview:
- Two-master arbiter for the single sysbus IO slave port.
- Sits between two bus masters (m0: CPU data port, m1: debug/DMA master) and the IO device block.
- Uses round-robin grant and the four-phase valid/ready handshake of the IO port.
- A watchdog completes any slave transaction that stalls, so a hung device cannot lock the bus.

Parameters:
- TIMEOUT_CYCLES, 256: max cycles the slave ready may stay low after s_valid rises before the arbiter aborts the transaction (≥2).
- TIMEOUT_DATA, 32'hDEAD_BEEF: read data returned to the master on timeout.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- m0_valid / m1_valid  in  1  master request; held high until the master sees its ready.
- m0_write / m1_write  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  32  IO address.
- m0_data / m1_data  in  32  write data.
- m0_ready / m1_ready  out  1  transaction complete; held high until the master drops valid.
- m0_rdata / m1_rdata  out  32  read data, valid while the matching ready is high.
- s_valid  out  1  request to the IO slave.
- s_write  out  1  forwarded write flag.
- s_addr  out  32  forwarded address.
- s_data  out  32  forwarded write data.
- s_ready  in  1  slave completion; slave keeps it high until s_valid drops.
- s_rdata  in  32  slave read data.
- timeout_err  out  1  one-cycle pulse when a transaction is aborted by the watchdog.

Behaviour:
- Reset (async assert, sync-released use):
  - Outputs: all ready, s_valid and timeout_err = 0; rdata, s_addr, s_data, s_write = 0.
  - state = IDLE, rr_last = 1 (m0 has first priority), cnt = 0.
- State IDLE:
  - If exactly one valid is high, grant it.
  - If both are high, grant the master other than rr_last.
  - On grant, register the master's write, addr and data into s_write, s_addr, s_data; s_valid <= 1; gnt <= index; cnt <= 0; go to BUSY.
  - Request fields are captured once; later changes on the master inputs are ignored.
- State BUSY:
  - If s_ready: m[gnt]_rdata <= s_rdata (writes return whatever the slave drives); m[gnt]_ready <= 1; s_valid <= 0; go to DONE.
  - Else, if cnt == TIMEOUT_CYCLES-1: m[gnt]_rdata <= TIMEOUT_DATA; m[gnt]_ready <= 1; s_valid <= 0; timeout_err <= 1 for one cycle; go to DONE.
  - Otherwise cnt <= cnt+1.
  - cnt width = clog2(TIMEOUT_CYCLES); it never wraps.
- State DONE:
  - Wait until m[gnt]_valid == 0 and s_ready == 0.
  - Then m[gnt]_ready <= 0; rr_last <= gnt; go to IDLE.
  - A late s_ready arriving after a timeout is absorbed here and never forwarded.
- Latency with a 1-cycle slave:
  - Master valid sampled at cycle 0; s_valid high at cycle 1; s_ready at cycle 2; m_ready at cycle 3.
  - Master drops valid at cycle 4; m_ready falls at cycle 5, provided s_ready has fallen.
  - Next grant is possible at cycle 6.
- The ungranted master's ready stays 0 throughout; its valid is simply held pending.
- A master dropping valid during BUSY is a protocol violation. The arbiter still completes the slave transaction; ready pulses for one cycle in DONE before returning to IDLE.
- Reset asserted mid-transaction: everything returns immediately to reset values, including s_valid = 0. The slave sees valid fall and releases ready.
- No combinational path from any input to any output.

Test Plan:
- m0 read 0xFE000010, slave answers 0x00001234 after 1 cycle:
  - s_valid rises at cycle 1 with s_addr = 0xFE000010, s_write = 0.
  - m0_ready at cycle 3 with m0_rdata = 0x00001234; m1_ready stays 0.
- m0 and m1 both raise valid in the same cycle, repeated 4 times (m0 addr 0xFE000010, m1 addr 0xFE000014):
  - Slave sees addresses in the order 0xFE000010, 0xFE000014, 0xFE000010, 0xFE000014.
- m1 write 0xFE000000 data 0x41 while m0 idle:
  - s_write = 1, s_data = 0x41; m1_ready returns.
  - Then m1 issues again immediately: granted again, since m0 is not requesting.
- Slave never asserts ready, TIMEOUT_CYCLES = 16:
  - timeout_err pulses exactly once, 16 cycles after s_valid rose; s_valid falls in the same cycle.
  - m0_rdata = 0xDEADBEEF; s_ready asserted late is ignored.
- rst_n pulled low while in BUSY with s_valid = 1:
  - s_valid, m0_ready, m1_ready are 0 in the same cycle, without a clock edge.
  - After release, the first request by m0 is granted normally.
- m0 changes addr from 0xFE000010 to 0xFE000014 while BUSY:
  - s_addr stays 0xFE000010 until DONE.

Source files
------------

// File: rtl/io_bus_arbiter.sv
// ---------------------------------------------------------------------------
// io_bus_arbiter
//   Round-robin arbiter that lets two bus masters share the single sysbus IO
//   slave port. m0 is the CPU data port and m1 is the debug/DMA master. Both
//   sides use a four-phase valid/ready handshake. A watchdog completes any
//   slave transaction that stalls, so a hung device cannot lock the bus.
//
// Parameters
//   TIMEOUT_CYCLES  cycles s_ready may stay low after s_valid rises (>= 2)
//   TIMEOUT_DATA    read data returned to the master on a watchdog abort
//
// Ports
//   clk            system clock, all logic on posedge
//   rst_n          asynchronous active-low reset
//   mX_valid_i     master request, held until the master sees its ready
//   mX_write_i     1 = write, 0 = read
//   mX_addr_i      IO address
//   mX_data_i      write data
//   mX_ready_o     transaction complete, held until the master drops valid
//   mX_rdata_o     read data, valid while the matching ready is high
//   s_valid_o      request to the IO slave
//   s_write_o      forwarded write flag
//   s_addr_o       forwarded address
//   s_data_o       forwarded write data
//   s_ready_i      slave completion, held until s_valid drops
//   s_rdata_i      slave read data
//   timeout_err_o  one-cycle pulse when the watchdog aborts a transaction
//
// All outputs come straight from registers.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no transaction; pick a master and capture its request
// BUSY    | s_valid high, waiting for s_ready or the watchdog
// DONE    | granted master's ready high; wait for its valid and s_ready low
// ---------------------------------------------------------------------------
module io_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_valid_i,
  input  logic        m0_write_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_ready_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_valid_i,
  input  logic        m1_write_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic        m1_ready_o,
  output logic [31:0] m1_rdata_o,

  output logic        s_valid_o,
  output logic        s_write_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic        s_ready_i,
  input  logic [31:0] s_rdata_i,

  output logic        timeout_err_o
);

  localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic           gnt_q;
  logic           rr_last_q;
  logic [CW-1:0]  cnt_q;
  logic           s_valid_q;
  logic           s_write_q;
  logic [31:0]    s_addr_q;
  logic [31:0]    s_data_q;
  logic           m0_ready_q;
  logic           m1_ready_q;
  logic [31:0]    m0_rdata_q;
  logic [31:0]    m1_rdata_q;
  logic           timeout_err_q;

  // Next-grant decode: a lone requester wins; on a tie the master that was
  // not served last wins.
  logic           any_req;
  logic           gnt_d;
  logic           sel_write;
  logic [31:0]    sel_addr;
  logic [31:0]    sel_data;
  logic           gnt_valid;
  logic [CW-1:0]  cnt_d;

  assign any_req = m0_valid_i | m1_valid_i;

  always_comb begin
    gnt_d = 1'b0;
    if (m0_valid_i && m1_valid_i) begin
      gnt_d = ~rr_last_q;
    end else if (m1_valid_i) begin
      gnt_d = 1'b1;
    end
  end

  assign sel_write = gnt_d ? m1_write_i : m0_write_i;
  assign sel_addr  = gnt_d ? m1_addr_i  : m0_addr_i;
  assign sel_data  = gnt_d ? m1_data_i  : m0_data_i;

  // Valid of the master that currently owns the slave.
  assign gnt_valid = gnt_q ? m1_valid_i : m0_valid_i;

  // Saturating increment; the terminal-count compare in BUSY fires before the
  // saturation point is ever reached, so the counter cannot wrap.
  assign cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      gnt_q         <= 1'b0;
      rr_last_q     <= 1'b1;
      cnt_q         <= '0;
      s_valid_q     <= 1'b0;
      s_write_q     <= 1'b0;
      s_addr_q      <= '0;
      s_data_q      <= '0;
      m0_ready_q    <= 1'b0;
      m1_ready_q    <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            s_write_q <= sel_write;
            s_addr_q  <= sel_addr;
            s_data_q  <= sel_data;
            s_valid_q <= 1'b1;
            gnt_q     <= gnt_d;
            cnt_q     <= '0;
            state_q   <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          // A completing slave takes precedence over the watchdog in the
          // terminal cycle.
          if (s_ready_i) begin
            if (gnt_q) begin
              m1_rdata_q <= s_rdata_i;
              m1_ready_q <= 1'b1;
            end else begin
              m0_rdata_q <= s_rdata_i;
              m0_ready_q <= 1'b1;
            end
            s_valid_q <= 1'b0;
            state_q   <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            if (gnt_q) begin
              m1_rdata_q <= TIMEOUT_DATA;
              m1_ready_q <= 1'b1;
            end else begin
              m0_rdata_q <= TIMEOUT_DATA;
              m0_ready_q <= 1'b1;
            end
            s_valid_q     <= 1'b0;
            timeout_err_q <= 1'b1;
            state_q       <= ST_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        ST_DONE: begin
          // Waiting for s_ready low as well absorbs a late slave completion
          // after a watchdog abort.
          if (!gnt_valid && !s_ready_i) begin
            if (gnt_q) begin
              m1_ready_q <= 1'b0;
            end else begin
              m0_ready_q <= 1'b0;
            end
            rr_last_q <= gnt_q;
            state_q   <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_ready_o    = m0_ready_q;
  assign m1_ready_o    = m1_ready_q;
  assign m0_rdata_o    = m0_rdata_q;
  assign m1_rdata_o    = m1_rdata_q;
  assign s_valid_o     = s_valid_q;
  assign s_write_o     = s_write_q;
  assign s_addr_o      = s_addr_q;
  assign s_data_o      = s_data_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_io_bus_arbiter
//   Self-checking bench for io_bus_arbiter with TIMEOUT_CYCLES = 16. A slave
//   model answers after a programmable latency with s_addr ^ slv_key; the
//   expected grant order and results come from a transaction-level
//   round-robin model (who was served last, timeout iff latency >= 16).
// ---------------------------------------------------------------------------
module tb_io_bus_arbiter;

  localparam int          TO      = 16;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic        m0_valid_i, m0_write_i, m1_valid_i, m1_write_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic        m0_ready_o, m1_ready_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_valid_o, s_write_o, s_ready_i, timeout_err_o;
  logic [31:0] s_addr_o, s_data_o, s_rdata_i;

  io_bus_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_DATA   (TO_DATA)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m0_valid_i    (m0_valid_i),
    .m0_write_i    (m0_write_i),
    .m0_addr_i     (m0_addr_i),
    .m0_data_i     (m0_data_i),
    .m0_ready_o    (m0_ready_o),
    .m0_rdata_o    (m0_rdata_o),
    .m1_valid_i    (m1_valid_i),
    .m1_write_i    (m1_write_i),
    .m1_addr_i     (m1_addr_i),
    .m1_data_i     (m1_data_i),
    .m1_ready_o    (m1_ready_o),
    .m1_rdata_o    (m1_rdata_o),
    .s_valid_o     (s_valid_o),
    .s_write_o     (s_write_o),
    .s_addr_o      (s_addr_o),
    .s_data_o      (s_data_o),
    .s_ready_i     (s_ready_i),
    .s_rdata_i     (s_rdata_i),
    .timeout_err_o (timeout_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave model: ready goes high slv_lat cycles after it first sees s_valid
  // and stays high until s_valid drops. slv_late forces ready high while idle.
  int          slv_lat  = 1;
  int          slv_w    = 0;
  logic [31:0] slv_key  = 32'h0;
  bit          slv_late = 1'b0;

  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n || !s_valid_o) begin
      slv_w     = 0;
      s_ready_i = slv_late;
    end else begin
      slv_w++;
      if (slv_w > slv_lat) begin
        s_ready_i = 1'b1;
        s_rdata_i = s_addr_o ^ slv_key;
      end
    end
  end

  // Monitor: records every slave request, watchdog pulses and ready activity.
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic        obs_wr[$];
  int  sv_rise_cyc = 0, to_cyc = 0, to_pulses = 0;
  int  both_ready = 0, addr_changes = 0, m0_rdy_cycles = 0, m1_rdy_cycles = 0;
  bit  sv_at_to = 1'b0;
  logic        sv_prev = 1'b0;
  logic [31:0] addr_prev = 32'h0;

  initial forever begin
    @(negedge clk);
    if (s_valid_o && !sv_prev) begin
      sv_rise_cyc = cyc;
      obs_addr.push_back(s_addr_o);
      obs_data.push_back(s_data_o);
      obs_wr.push_back(s_write_o);
    end
    if (s_valid_o && sv_prev && (s_addr_o != addr_prev)) addr_changes++;
    if (timeout_err_o) begin
      to_pulses++;
      to_cyc   = cyc;
      sv_at_to = s_valid_o;
    end
    if (m0_ready_o && m1_ready_o) both_ready++;
    if (m0_ready_o) m0_rdy_cycles++;
    if (m1_ready_o) m1_rdy_cycles++;
    sv_prev   = s_valid_o;
    addr_prev = s_addr_o;
  end

  function automatic logic [31:0] obs_a(input int i);
    if (i < obs_addr.size()) return obs_addr[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] obs_d(input int i);
    if (i < obs_data.size()) return obs_data[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic obs_w(input int i);
    if (i < obs_wr.size()) return obs_wr[i];
    return 1'bx;
  endfunction

  task automatic put(input bit m, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (m) begin
      m1_write_i = w; m1_addr_i = a; m1_data_i = d; m1_valid_i = 1'b1;
    end else begin
      m0_write_i = w; m0_addr_i = a; m0_data_i = d; m0_valid_i = 1'b1;
    end
  endtask

  int m0_rdy_cyc = 0, m1_rdy_cyc = 0;

  // Master side: drop valid as soon as ready is seen, then wait for both
  // readies to return low.
  task automatic serve(input bit [1:0] req, output logic [31:0] rd0, output logic [31:0] rd1);
    bit [1:0] pend;
    int       budget;
    pend   = req;
    budget = 400;
    rd0    = 32'hxxxx_xxxx;
    rd1    = 32'hxxxx_xxxx;
    while ((pend != 2'b00 || m0_ready_o || m1_ready_o) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
      if (pend[0] && m0_ready_o) begin
        rd0 = m0_rdata_o; m0_valid_i = 1'b0; pend[0] = 1'b0; m0_rdy_cyc = cyc;
      end
      if (pend[1] && m1_ready_o) begin
        rd1 = m1_rdata_o; m1_valid_i = 1'b0; pend[1] = 1'b0; m1_rdy_cyc = cyc;
      end
    end
    chk("serve_done_in_budget", (budget > 0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1);
  end

  bit          mdl_rr;
  logic [31:0] rd0, rd1;
  int          n, p, t0, budget;

  initial begin
    rst_n = 1'b0;
    m0_valid_i = 0; m0_write_i = 0; m0_addr_i = 0; m0_data_i = 0;
    m1_valid_i = 0; m1_write_i = 0; m1_addr_i = 0; m1_data_i = 0;
    s_ready_i = 0; s_rdata_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_valid", s_valid_o, 0);
    chk("rst_m0_ready", m0_ready_o, 0);
    chk("rst_m1_ready", m1_ready_o, 0);
    chk("rst_timeout_err", timeout_err_o, 0);
    chk("rst_s_addr", s_addr_o, 0);
    chk("rst_s_data", s_data_o, 0);
    chk("rst_m0_rdata", m0_rdata_o, 0);
    rst_n  = 1'b1;
    mdl_rr = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single m0 read with a 1-cycle slave: latency and data.
    slv_lat = 1;
    slv_key = 32'hFE00_0010 ^ 32'h0000_1234;
    n  = m1_rdy_cycles;
    p  = obs_addr.size();
    t0 = cyc;
    put(0, 0, 32'hFE00_0010, 32'h0);
    serve(2'b01, rd0, rd1);
    chk("rd_sv_rise_cycle", sv_rise_cyc - t0, 1);
    chk("rd_s_addr", obs_a(p), 32'hFE00_0010);
    chk("rd_s_write", obs_w(p), 0);
    chk("rd_ready_cycle", m0_rdy_cyc - t0, 3);
    chk("rd_m0_rdata", rd0, 32'h0000_1234);
    chk("rd_m1_ready_idle", m1_rdy_cycles - n, 0);
    mdl_rr = 1'b0;

    // m1 write, then an immediate re-issue by m1 alone.
    slv_key = 32'h0BAD_0000;
    p = obs_addr.size();
    put(1, 1, 32'hFE00_0000, 32'h0000_0041);
    serve(2'b10, rd0, rd1);
    chk("wr_s_write", obs_w(p), 1);
    chk("wr_s_data", obs_d(p), 32'h0000_0041);
    chk("wr_m1_rdata", rd1, 32'hFE00_0000 ^ 32'h0BAD_0000);
    put(1, 1, 32'hFE00_0000, 32'h0000_0042);
    serve(2'b10, rd0, rd1);
    chk("wr_again_count", obs_addr.size() - p, 2);
    chk("wr_again_data", obs_d(p + 1), 32'h0000_0042);
    mdl_rr = 1'b1;

    // Simultaneous requests, four rounds.
    for (int r = 0; r < 4; r++) begin
      bit first;
      first = !mdl_rr;
      p = obs_addr.size();
      put(0, 0, 32'hFE00_0010, 32'h0);
      put(1, 0, 32'hFE00_0014, 32'h0);
      serve(2'b11, rd0, rd1);
      chk("rr_first", obs_a(p), first ? 32'hFE00_0014 : 32'hFE00_0010);
      chk("rr_second", obs_a(p + 1), first ? 32'hFE00_0010 : 32'hFE00_0014);
      chk("rr_m0_rdata", rd0, 32'hFE00_0010 ^ slv_key);
      mdl_rr = !first;
    end

    // Watchdog abort, then a late s_ready that must be absorbed.
    slv_lat = 1000;
    p = to_pulses;
    put(0, 0, 32'hFE00_0020, 32'h0);
    budget = 100;
    while (!m0_ready_o && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    chk("to_ready_seen", m0_ready_o, 1);
    m0_valid_i = 1'b0;
    slv_late   = 1'b1;
    s_ready_i  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("to_m0_rdata", m0_rdata_o, TO_DATA);
    chk("to_pulse_count", to_pulses - p, 1);
    chk("to_delay", to_cyc - sv_rise_cyc, TO);
    chk("to_s_valid_low", sv_at_to, 0);
    chk("to_held_by_late_ready", m0_ready_o, 1);
    slv_late  = 1'b0;
    s_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("to_release", m0_ready_o, 0);
    chk("to_pulse_count_after", to_pulses - p, 1);
    chk("to_rdata_kept", m0_rdata_o, TO_DATA);
    mdl_rr = 1'b0;

    // Master drops valid right after being granted: ready pulses once.
    slv_lat = 2;
    n = m0_rdy_cycles;
    put(0, 0, 32'hFE00_0030, 32'h0);
    @(posedge clk);
    #1;
    m0_valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pv_ready_one_cycle", m0_rdy_cycles - n, 1);
    mdl_rr = 1'b0;

    // Address changes on the master while BUSY are ignored.
    slv_lat = 6;
    p = obs_addr.size();
    put(0, 0, 32'hFE00_0010, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    m0_addr_i = 32'hFE00_0014;
    repeat (2) @(posedge clk);
    #1;
    chk("ac_s_valid_busy", s_valid_o, 1);
    chk("ac_s_addr_busy", s_addr_o, 32'hFE00_0010);
    serve(2'b01, rd0, rd1);
    chk("ac_s_addr_obs", obs_a(p), 32'hFE00_0010);
    chk("ac_m0_rdata", rd0, 32'hFE00_0010 ^ slv_key);
    mdl_rr = 1'b0;

    // Asynchronous reset in the middle of BUSY.
    slv_lat = 10;
    put(0, 0, 32'hFE00_0040, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rb_busy_before", s_valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rb_s_valid", s_valid_o, 0);
    chk("rb_m0_ready", m0_ready_o, 0);
    chk("rb_m1_ready", m1_ready_o, 0);
    chk("rb_s_addr", s_addr_o, 0);
    m0_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mdl_rr = 1'b1;
    @(posedge clk);
    #1;
    slv_lat = 1;
    p = obs_addr.size();
    put(0, 0, 32'hFE00_0044, 32'h0);
    serve(2'b01, rd0, rd1);
    chk("rb_after_addr", obs_a(p), 32'hFE00_0044);
    chk("rb_after_rdata", rd0, 32'hFE00_0044 ^ slv_key);
    mdl_rr = 1'b0;

    // Randomized traffic against the transaction-level model.
    for (int r = 0; r < 30; r++) begin
      bit [1:0]    req;
      bit          first;
      int          nm, exp_to;
      logic [31:0] a [2];
      logic [31:0] d [2];
      logic        w [2];
      logic [31:0] exp_rd [2];
      req     = 2'($urandom_range(1, 3));
      slv_lat = ($urandom_range(0, 6) == 0) ? int'($urandom_range(16, 20))
                                            : int'($urandom_range(0, 6));
      slv_key = $urandom;
      a[0] = 32'hFE00_0000 | ($urandom & 32'h0000_00FC);
      a[1] = a[0] ^ 32'h0000_0100;
      d[0] = $urandom;
      d[1] = $urandom;
      w[0] = 1'($urandom_range(0, 1));
      w[1] = 1'($urandom_range(0, 1));
      for (int m = 0; m < 2; m++)
        exp_rd[m] = (slv_lat >= TO) ? TO_DATA : (a[m] ^ slv_key);
      nm    = (req == 2'b11) ? 2 : 1;
      first = (req == 2'b11) ? !mdl_rr : (req == 2'b10);
      exp_to = (slv_lat >= TO) ? nm : 0;
      p = obs_addr.size();
      n = to_pulses;
      if (req[0]) put(0, w[0], a[0], d[0]);
      if (req[1]) put(1, w[1], a[1], d[1]);
      serve(req, rd0, rd1);
      chk("rnd_count", obs_addr.size() - p, nm);
      chk("rnd_addr0", obs_a(p), a[first]);
      chk("rnd_data0", obs_d(p), d[first]);
      chk("rnd_write0", obs_w(p), w[first]);
      if (nm == 2) begin
        chk("rnd_addr1", obs_a(p + 1), a[!first]);
        chk("rnd_data1", obs_d(p + 1), d[!first]);
        chk("rnd_write1", obs_w(p + 1), w[!first]);
      end
      if (req[0]) chk("rnd_m0_rdata", rd0, exp_rd[0]);
      if (req[1]) chk("rnd_m1_rdata", rd1, exp_rd[1]);
      chk("rnd_timeouts", to_pulses - n, exp_to);
      mdl_rr = (nm == 2) ? !first : first;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    chk("never_both_ready", both_ready, 0);
    chk("s_addr_stable_while_valid", addr_changes, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
